// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4:1 TDM demultiplexer: FSM state encoding and slot count.
package tdm_demux4_pkg;

    localparam int NSLOT  = 4;
    localparam int SLOT_W = $clog2(NSLOT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAR  = 2'd2
    } state_t;

endpackage

// File: rtl/tdm_demux4_slot_ctr.sv
// Slot index counter for tdm_demux4; priority is clear, then load-1, then increment.
module slot_ctr
    import tdm_demux4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ld1,
    input  logic              en,
    output logic [SLOT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (ld1) cnt <= SLOT_W'(1);
        else if (en)  cnt <= cnt + SLOT_W'(1);
    end

endmodule

// File: rtl/tdm_demux4.sv
// 4:1 TDM demultiplexer: frame-aligned slot capture into w0..w3 with resync on misplaced frame.
// Optional per-frame parity beat is compiled in with TDM_DEMUX4_PARITY_EN.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             valid_in,
    input  logic             frame,
    output logic [WIDTH-1:0] w0,
    output logic [WIDTH-1:0] w1,
    output logic [WIDTH-1:0] w2,
    output logic [WIDTH-1:0] w3,
    output logic             s1,
    output logic             s0,
    output logic             out_valid,
    output logic             sync_err
);

    // Slot 3 arrives straight from din unless a parity beat follows it.
`ifdef TDM_DEMUX4_PARITY_EN
    localparam int NBUF = NSLOT;
`else
    localparam int NBUF = NSLOT - 1;
`endif

    state_t                      state;
    logic [NBUF-1:0][WIDTH-1:0]  slot_buf;
    logic [SLOT_W-1:0]           idx;
    logic                        last_slot;
    logic                        ctr_clr;
    logic                        ctr_ld1;
    logic                        ctr_en;

    assign {s1, s0}  = idx;
    assign last_slot = (idx == SLOT_W'(NSLOT - 1));

    assign ctr_ld1 = valid_in && frame;
    assign ctr_clr = valid_in && !frame &&
                     ((state == RUN && last_slot) || state == PAR);
    assign ctr_en  = valid_in && !frame && state == RUN && !last_slot;

    slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .ld1   (ctr_ld1),
        .en    (ctr_en),
        .cnt   (idx)
    );

`ifdef TDM_DEMUX4_PARITY_EN
    logic [WIDTH-1:0] word_xor;
    logic             par_ok;

    always_comb begin
        word_xor = '0;
        for (int i = 0; i < NSLOT; i++) word_xor = word_xor ^ slot_buf[i];
    end

    // Parity bit is bit 0 of the word-wise XOR of the four slots.
    assign par_ok = (din[0] == word_xor[0]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slot_buf  <= '0;
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            w3        <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (valid_in) begin
                case (state)
                    IDLE: begin
                        if (frame) begin
                            slot_buf[0] <= din;
                            state       <= RUN;
                        end
                    end
                    RUN: begin
                        if (frame) begin
                            sync_err    <= 1'b1;
                            slot_buf[0] <= din;
                        end else if (last_slot) begin
`ifdef TDM_DEMUX4_PARITY_EN
                            slot_buf[NSLOT-1] <= din;
                            state             <= PAR;
`else
                            w0        <= slot_buf[0];
                            w1        <= slot_buf[1];
                            w2        <= slot_buf[2];
                            w3        <= din;
                            out_valid <= 1'b1;
                            state     <= IDLE;
`endif
                        end else begin
                            for (int i = 1; i < NBUF; i++)
                                if (idx == SLOT_W'(i)) slot_buf[i] <= din;
                        end
                    end
`ifdef TDM_DEMUX4_PARITY_EN
                    PAR: begin
                        if (frame) begin
                            sync_err    <= 1'b1;
                            slot_buf[0] <= din;
                            state       <= RUN;
                        end else begin
                            if (par_ok) begin
                                w0        <= slot_buf[0];
                                w1        <= slot_buf[1];
                                w2        <= slot_buf[2];
                                w3        <= slot_buf[3];
                                out_valid <= 1'b1;
                            end else begin
                                sync_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized + directed bench for tdm_demux4 against a queue-based frame model.
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         valid_in = 1'b0;
    logic         frame = 1'b0;
    logic [W-1:0] w0, w1, w2, w3;
    logic         s1, s0, out_valid, sync_err;

    int n_chk = 0;
    int n_bad = 0;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .valid_in  (valid_in),
        .frame     (frame),
        .w0        (w0),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .s1        (s1),
        .s0        (s0),
        .out_valid (out_valid),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: words collected since the last frame beat.
    logic [W-1:0] mq[$];
    bit           m_act;
    bit           m_par;
    logic [W-1:0] mw[4];
    bit           m_ov, m_se;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_act = 0;
        m_par = 0;
        m_ov  = 0;
        m_se  = 0;
        for (int i = 0; i < 4; i++) mw[i] = '0;
    endtask

    task automatic model_beat(input logic v, input logic f, input logic [W-1:0] d);
        logic [W-1:0] x;
        m_ov = 0;
        m_se = 0;
        if (!v) return;
        if (f) begin
            if (m_act) m_se = 1;
            mq.delete();
            mq.push_back(d);
            m_act = 1;
            m_par = 0;
        end else if (m_par) begin
            x = mq[0] ^ mq[1] ^ mq[2] ^ mq[3];
            if (d[0] == x[0]) begin
                for (int i = 0; i < 4; i++) mw[i] = mq[i];
                m_ov = 1;
            end else begin
                m_se = 1;
            end
            m_act = 0;
            m_par = 0;
            mq.delete();
        end else if (m_act) begin
            mq.push_back(d);
            if (mq.size() == 4) begin
`ifdef TDM_DEMUX4_PARITY_EN
                m_par = 1;
`else
                for (int i = 0; i < 4; i++) mw[i] = mq[i];
                m_ov  = 1;
                m_act = 0;
                mq.delete();
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        int   sz;
        logic [1:0] eidx;
        sz   = mq.size();
        eidx = (m_act && !m_par) ? 2'(sz) : 2'd0;
        chk({tag, "_w"}, {w0, w1, w2, w3}, {mw[0], mw[1], mw[2], mw[3]});
        chk({tag, "_idx"}, {s1, s0}, eidx);
        chk({tag, "_ovld"}, out_valid, m_ov);
        chk({tag, "_serr"}, sync_err, m_se);
    endtask

    // Apply one beat for one clock, advance the model, compare 1ns after the edge.
    task automatic step(input logic v, input logic f, input logic [W-1:0] d, input string tag);
        valid_in = v;
        frame    = f;
        din      = d;
        @(posedge clk);
        model_beat(v, f, d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        valid_in = 0;
        frame    = 0;
        rst_n    = 1'b1;
    endtask

    task automatic send_frame(input logic [4*W-1:0] f, input string tag);
        for (int i = 0; i < 4; i++)
            step(1'b1, i == 0, f[(3-i)*W +: W], tag);
`ifdef TDM_DEMUX4_PARITY_EN
        step(1'b1, 1'b0, {{(W-1){1'b0}}, ^{f[0], f[W], f[2*W], f[3*W]}}, tag);
`endif
    endtask

    initial begin
        model_reset();
        #3;
        do_reset("reset");

        // Consecutive frame A,5,C,3 with index stepping 1,2,3,0.
        step(1, 1, 4'hA, "f1");
        chk("f1_s1", {s1, s0}, 2'd1);
        step(1, 0, 4'h5, "f1");
        chk("f1_s2", {s1, s0}, 2'd2);
        step(1, 0, 4'hC, "f1");
        chk("f1_s3", {s1, s0}, 2'd3);
        step(1, 0, 4'h3, "f1");
`ifdef TDM_DEMUX4_PARITY_EN
        step(1, 0, 4'h0, "f1p");
`endif
        chk("f1_words", {w0, w1, w2, w3}, 16'hA5C3);
        chk("f1_pulse", out_valid, 1'b1);
        step(0, 0, 4'h0, "gap");

        // Gap of three idle cycles between slots 1 and 2.
        step(1, 1, 4'h6, "f2");
        step(1, 0, 4'hB, "f2");
        for (int i = 0; i < 3; i++) step(0, 0, 4'(i), "f2gap");
        step(1, 0, 4'hD, "f2");
        step(1, 0, 4'h1, "f2");
`ifdef TDM_DEMUX4_PARITY_EN
        step(1, 0, 4'h1, "f2p");
`endif
        chk("f2_words", {w0, w1, w2, w3}, 16'h6BD1);

        // Resync: 1,2 then frame 7, then 8,9,F.
        step(1, 1, 4'h1, "rs");
        step(1, 0, 4'h2, "rs");
        step(1, 1, 4'h7, "rs");
        chk("rs_err", sync_err, 1'b1);
        chk("rs_hold", {w0, w1, w2, w3}, 16'h6BD1);
        step(1, 0, 4'h8, "rs");
        step(1, 0, 4'h9, "rs");
        step(1, 0, 4'hF, "rs");
`ifdef TDM_DEMUX4_PARITY_EN
        step(1, 0, 4'h1, "rsp");
`endif
        chk("rs_words", {w0, w1, w2, w3}, 16'h789F);

        // Idle beats without frame are ignored; then back-to-back frames.
        for (int i = 0; i < 4; i++) step(1, 0, 4'(i + 3), "idle");
        send_frame(16'h1234, "b2b");
        send_frame(16'hFEDC, "b2b");
        chk("b2b_words", {w0, w1, w2, w3}, 16'hFEDC);

        // Reset after slot 2, then a full frame.
        step(1, 1, 4'h4, "mr");
        step(1, 0, 4'h4, "mr");
        step(1, 0, 4'h4, "mr");
        do_reset("mr_rst");
        chk("mr_zero", {w0, w1, w2, w3}, 16'h0);
        step(1, 0, 4'h9, "mr_nof");
        send_frame(16'h5A5A, "mr");
        chk("mr_words", {w0, w1, w2, w3}, 16'h5A5A);

`ifdef TDM_DEMUX4_PARITY_EN
        // Parity: slots 1,2,4,8 with good then bad parity bit.
        for (int p = 1; p >= 0; p--) begin
            step(1, 1, 4'h1, "par");
            step(1, 0, 4'h2, "par");
            step(1, 0, 4'h4, "par");
            step(1, 0, 4'h8, "par");
            step(1, 0, 4'(p), "par");
            chk("par_ov", out_valid, p[0]);
            chk("par_se", sync_err, !p[0]);
            chk("par_words", {w0, w1, w2, w3}, 16'h1248);
        end
`endif

        // Randomized beats with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
                     4'($urandom), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: WIDTH, default 4, bits per slot word.
REQ-002 Port: clk  input  1  the block's only clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: din  input  WIDTH  multiplexed slot word from the 4:1 TDM sender.
REQ-005 Port: valid_in  input  1  din carries a slot word this cycle.
REQ-006 Port: frame  input  1  qualified by valid_in; marks din as slot 0.
REQ-007 Port: w0, w1, w2, w3  output  WIDTH each  demultiplexed slot registers.
REQ-008 Port: s1, s0  output  1 each  current expected slot index {s1,s0}.
REQ-009 Port: out_valid  output  1  one-cycle pulse when w0..w3 hold a new complete frame.
REQ-010 Port: sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, plus PAR only when parity is compiled in.
REQ-012 IDLE: a beat without frame is discarded; valid_in&&frame stores din as slot 0, sets {s1,s0}=1, enters RUN.
REQ-013 RUN: each valid_in beat without frame stores din into the slot-{s1,s0} buffer and increments {s1,s0}.
REQ-014 Cycles with valid_in=0 SHALL change no state, slot index or output; gaps of any length are allowed.
REQ-015 The edge that stores slot 3 SHALL load w0..w3 together, slot 3 taken directly from din, and set out_valid high for exactly the following cycle.
REQ-016 w0..w3 SHALL hold their value between completed frames; partial frames never reach them.
REQ-017 After slot 3 the index SHALL wrap to 0 and the FSM SHALL go to IDLE, awaiting the next frame beat; back-to-back frames without idle cycles SHALL be supported.
REQ-018 frame with valid_in at slot index 1..3 SHALL pulse sync_err, discard the partial frame, store din as slot 0 and set {s1,s0}=1 (resync).
REQ-019 In IDLE, {s1,s0} SHALL read 0.
REQ-020 out_valid and sync_err SHALL be registered; they are never high in the same cycle.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, {s1,s0}=0, w0..w3=0, slot buffers=0, out_valid=0, sync_err=0.
REQ-022 Reset mid-frame SHALL discard the partial frame; after release the first accepted beat SHALL be a frame beat.

Configuration
REQ-023 Macro TDM_DEMUX4_PARITY_EN, when defined, SHALL add a PAR state entered after slot 3; the next valid beat's din[0] is the parity bit.
REQ-024 With the macro: w0..w3 load and out_valid pulse on the parity beat only if din[0] equals XOR-reduction of all four slots; on mismatch sync_err pulses and outputs hold.
REQ-025 With the macro: frame asserted on the parity beat SHALL count as a sync error plus slot 0 per REQ-018.
REQ-026 Without the macro: no PAR state and no parity logic; behaviour is exactly REQ-015.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1, PAR=2) and the slot-count constant NSLOT=4.
REQ-028 Sub-module slot_ctr SHALL hold the 2-bit slot counter with its clear, load-1 and enable inputs; all else stays in tdm_demux4.

Verification (WIDTH=4)
REQ-029 Reset; then frame beats A,5,C,3 on consecutive cycles -> next cycle out_valid=1, w0..w3=A,5,C,3; {s1,s0} steps 1,2,3,0.
REQ-030 Same frame with valid_in low for 3 cycles between slots 1 and 2 -> identical result, out_valid only after slot 3.
REQ-031 Frame beats 1,2, then frame beat 7 -> sync_err pulse, w0..w3 unchanged; then beats 8,9,F -> w0..w3=7,8,9,F.
REQ-032 In IDLE, beats without frame -> all ignored, no pulses; two back-to-back frames -> two out_valid pulses 4 cycles apart.
REQ-033 rst_n low after slot 2 -> all outputs 0 at once; a following full frame completes normally.
REQ-034 Parity build: slots 1,2,4,8 (XOR=F, bit0=1) with parity 1 -> out_valid; same slots with parity 0 -> sync_err, outputs hold.
